mem_port_arbiter: RTL

//  Shares the single-port 16-bit synchronous memory between the instruction-fetch port and the data load/store port.

---
 rtl/cpu_mem_pkg.sv | 20 ++
 rtl/mem_port_arbiter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared types for the CPU memory-port arbiter.
//   arb_state_t : arbiter FSM state (idle / second beat of a word access)
//   owner_t     : requester owning the read data returning this cycle
package cpu_mem_pkg;

  localparam int unsigned HALF_W = 16;
  localparam int unsigned WORD_W = 32;

  typedef enum logic {
    ARB_IDLE    = 1'b0,
    ARB_WORD_HI = 1'b1
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares a single-port 16-bit synchronous memory between instruction fetch and
// the data load/store port. Word data accesses are split into two halfword beats
// (low half first). Data wins arbitration unless fetch has been starved for
// STARVE_LIMIT consecutive data grants.
// Ports:
//   clk, rst                      clock, async active-high reset
//   if_req/if_addr                fetch request (held until if_gnt)
//   if_gnt/if_rvalid/if_rdata     fetch grant, read data valid one cycle later
//   d_req/d_we/d_word/d_addr/d_wdata  data request (held until d_gnt)
//   d_gnt/d_ack/d_err/d_rdata     data grant, completion, misalignment error, read data
//   mem_en/mem_rd_en/mem_wr_en/mem_addr/mem_din/mem_dout  memory command port
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int unsigned MEM_DEPTH    = 4096,
  parameter int unsigned ADDR_WIDTH   = $clog2(MEM_DEPTH),
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [HALF_W-1:0]     if_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic                  d_word,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [WORD_W-1:0]     d_wdata,
  output logic                  d_gnt,
  output logic                  d_ack,
  output logic                  d_err,
  output logic [WORD_W-1:0]     d_rdata,
  output logic                  mem_en,
  output logic                  mem_rd_en,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [HALF_W-1:0]     mem_din,
  input  logic [HALF_W-1:0]     mem_dout
);

  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

  arb_state_t            state_q, state_d;
  owner_t                owner_q, owner_d;
  logic                  d_ack_q, d_ack_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;          // address of the second beat
  logic                  we_q, we_d;
  logic                  word_q, word_d;
  logic [HALF_W-1:0]     wdata_hi_q, wdata_hi_d;
  logic [HALF_W-1:0]     lo_q, lo_d;
  logic [STARVE_W-1:0]   starve_q, starve_d;
  logic [WORD_W-1:0]     d_rdata_q, d_rdata_d;

  logic                  rd_ack;
  logic [WORD_W-1:0]     rd_data;

  // Arbitration and memory command decode; everything idle while in reset.
  always_comb begin
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    d_err     = 1'b0;
    mem_en    = 1'b0;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    mem_addr  = '0;
    mem_din   = '0;
    if (!rst) begin
      case (state_q)
        ARB_IDLE: begin
          if (if_req && (!d_req || starve_q == STARVE_W'(STARVE_LIMIT))) begin
            if_gnt    = 1'b1;
            mem_en    = 1'b1;
            mem_rd_en = 1'b1;
            mem_addr  = if_addr;
          end else if (d_req) begin
            d_gnt = 1'b1;
            if (d_word && d_addr[0]) begin
              d_err = 1'b1;
            end else begin
              mem_en    = 1'b1;
              mem_rd_en = !d_we;
              mem_wr_en = d_we;
              mem_addr  = d_addr;
              if (d_we) mem_din = d_wdata[HALF_W-1:0];
            end
          end
        end
        ARB_WORD_HI: begin
          mem_en    = 1'b1;
          mem_rd_en = !we_q;
          mem_wr_en = we_q;
          mem_addr  = addr_q;
          if (we_q) mem_din = wdata_hi_q;
        end
        default: ;
      endcase
    end
  end

  // Read data for the current ack: word reads join the captured low half.
  assign rd_ack  = d_ack_q && (owner_q == OWN_D);
  assign rd_data = word_q ? {mem_dout, lo_q} : {HALF_W'(0), mem_dout};

  // Next-state, request latching, completion tracking and starvation counter.
  always_comb begin
    state_d    = state_q;
    owner_d    = OWN_NONE;
    d_ack_d    = 1'b0;
    addr_d     = addr_q;
    we_d       = we_q;
    word_d     = word_q;
    wdata_hi_d = wdata_hi_q;
    lo_d       = lo_q;
    starve_d   = starve_q;
    d_rdata_d  = rd_ack ? rd_data : d_rdata_q;

    if (if_gnt) owner_d = OWN_IF;

    if (d_gnt && !d_err) begin
      we_d       = d_we;
      word_d     = d_word;
      addr_d     = d_addr + ADDR_WIDTH'(1);
      wdata_hi_d = d_wdata[WORD_W-1:HALF_W];
      if (d_word) begin
        state_d = ARB_WORD_HI;
      end else begin
        d_ack_d = 1'b1;
        if (!d_we) owner_d = OWN_D;
      end
    end

    // Second beat: the first beat's read data arrives now.
    if (state_q == ARB_WORD_HI) begin
      state_d = ARB_IDLE;
      d_ack_d = 1'b1;
      if (!we_q) begin
        owner_d = OWN_D;
        lo_d    = mem_dout;
      end
    end

    if (!if_req || if_gnt) begin
      starve_d = '0;
    end else if (d_gnt && starve_q != STARVE_W'(STARVE_LIMIT)) begin
      starve_d = starve_q + STARVE_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      owner_q    <= OWN_NONE;
      d_ack_q    <= 1'b0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      word_q     <= 1'b0;
      wdata_hi_q <= '0;
      lo_q       <= '0;
      starve_q   <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      d_ack_q    <= d_ack_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      word_q     <= word_d;
      wdata_hi_q <= wdata_hi_d;
      lo_q       <= lo_d;
      starve_q   <= starve_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign if_rvalid = (owner_q == OWN_IF);
  assign if_rdata  = if_rvalid ? mem_dout : '0;
  assign d_ack     = d_ack_q;
  assign d_rdata   = d_rdata_d;

endmodule
